// File: rtl/fwd_hazard_unit_if.sv
// rtl/fwd_hazard_unit_if.sv - pipeline-side signal bundle for the forwarding/hazard unit
//
// Purpose: groups every pipeline-facing signal of fwd_hazard_unit so the unit
// can be dropped beside the ID/EX register with a single port.
// Modports:
//   master - the pipeline: drives stage write enables, destinations, source
//            addresses and MDU issue; receives Forward, Stall and MDU status.
//   slave  - the forwarding/hazard unit itself (the mirror of master).

interface fwd_hazard_unit_if #(
    parameter int AW   = 5,
    parameter int NSRC = 3
);
    logic                 Ex_Mem_RegWrite;
    logic                 Mem_Wb_RegWrite;
    logic [AW-1:0]        Ex_Mem_rd;
    logic [AW-1:0]        Mem_Wb_rd;
    logic [NSRC*AW-1:0]   Id_Ex_src;
    logic [NSRC*AW-1:0]   If_Id_src;
    logic [NSRC-1:0]      Id_Ex_src_en;
    logic [NSRC-1:0]      If_Id_src_en;
    logic                 Id_Ex_MemRead;
    logic [AW-1:0]        Id_Ex_rd;
    logic                 Mdu_start;
    logic [AW-1:0]        Mdu_rd;
    logic                 If_Id_mdu;
    logic [2*NSRC-1:0]    Forward;
    logic                 Stall;
    logic                 Mdu_busy;
    logic                 Mdu_done;
    logic [AW-1:0]        Mdu_wb_rd;
    logic                 Mdu_err;

    modport master (
        output Ex_Mem_RegWrite, Mem_Wb_RegWrite, Ex_Mem_rd, Mem_Wb_rd,
               Id_Ex_src, If_Id_src, Id_Ex_src_en, If_Id_src_en,
               Id_Ex_MemRead, Id_Ex_rd, Mdu_start, Mdu_rd, If_Id_mdu,
        input  Forward, Stall, Mdu_busy, Mdu_done, Mdu_wb_rd, Mdu_err
    );

    modport slave (
        input  Ex_Mem_RegWrite, Mem_Wb_RegWrite, Ex_Mem_rd, Mem_Wb_rd,
               Id_Ex_src, If_Id_src, Id_Ex_src_en, If_Id_src_en,
               Id_Ex_MemRead, Id_Ex_rd, Mdu_start, Mdu_rd, If_Id_mdu,
        output Forward, Stall, Mdu_busy, Mdu_done, Mdu_wb_rd, Mdu_err
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - operand forwarding, load-use and MDU hazard unit
//
// Purpose: drives the EX operand-mux selects (Forward, 2 bits per source slot)
// and the pipeline Stall line, and tracks a single multi-cycle MDU op.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - fwd_hazard_unit_if.slave: stage write enables/destinations, source
//           addresses and enables, load and MDU issue info in; Forward, Stall,
//           Mdu_busy, Mdu_done, Mdu_wb_rd, Mdu_err out.

module fwd_hazard_unit #(
    parameter int AW        = 5,
    parameter int NSRC      = 3,
    parameter int MDU_LAT   = 4,
    parameter int RF_BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    fwd_hazard_unit_if.slave  bus
);
    localparam int CW = $clog2(MDU_LAT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    mdu_state_t     state, state_nxt;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [AW-1:0]  pend_rd, pend_rd_nxt;
    logic           err, err_nxt;

    // One-cycle write-back history: covers a register file that reads the old
    // value in the same cycle it is written.
    logic           wb_last_we;
    logic [AW-1:0]  wb_last_rd;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_last_we <= 1'b0;
            wb_last_rd <= '0;
        end else if (RF_BYPASS == 0) begin
            wb_last_we <= bus.Mem_Wb_RegWrite;
            wb_last_rd <= bus.Mem_Wb_rd;
        end
    end

    // Per-slot forwarding select, youngest producer wins.
    always_comb begin
        bus.Forward = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.Id_Ex_src_en[i] && (bus.Id_Ex_src[i*AW +: AW] != '0)) begin
                if (bus.Ex_Mem_RegWrite && (bus.Ex_Mem_rd == bus.Id_Ex_src[i*AW +: AW]))
                    bus.Forward[2*i +: 2] = 2'b10;
                else if (bus.Mem_Wb_RegWrite && (bus.Mem_Wb_rd == bus.Id_Ex_src[i*AW +: AW]))
                    bus.Forward[2*i +: 2] = 2'b01;
                else if ((RF_BYPASS == 0) && wb_last_we && (wb_last_rd == bus.Id_Ex_src[i*AW +: AW]))
                    bus.Forward[2*i +: 2] = 2'b11;
            end
        end
    end

    // ID-stage source matches against the EX load and the pending MDU dest.
    logic load_use, mdu_raw;

    always_comb begin
        load_use = 1'b0;
        mdu_raw  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (bus.If_Id_src_en[i] && (bus.If_Id_src[i*AW +: AW] != '0)) begin
                if (bus.Id_Ex_MemRead && (bus.Id_Ex_rd == bus.If_Id_src[i*AW +: AW]))
                    load_use = 1'b1;
                if ((state != IDLE) && (pend_rd == bus.If_Id_src[i*AW +: AW]))
                    mdu_raw = 1'b1;
            end
        end
    end

    // A second MDU op in ID must wait while the unit is occupied; in DONE the
    // unit accepts a new issue, so no structural stall there.
    assign bus.Stall = load_use | mdu_raw | ((state == BUSY) && bus.If_Id_mdu);

    // MDU tracker. cnt loads MDU_LAT-2 so BUSY lasts MDU_LAT-1 cycles and
    // DONE lands exactly MDU_LAT cycles after the issuing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pend_rd <= '0;
            err     <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pend_rd <= pend_rd_nxt;
            err     <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        pend_rd_nxt = pend_rd;
        err_nxt     = err;
        case (state)
            IDLE: begin
                if (bus.Mdu_start) begin
                    pend_rd_nxt = bus.Mdu_rd;
                    cnt_nxt     = CW'(MDU_LAT - 2);
                    state_nxt   = BUSY;
                end
            end
            BUSY: begin
                if (bus.Mdu_start)
                    err_nxt = 1'b1;
                if (cnt == '0)
                    state_nxt = DONE;
                else
                    cnt_nxt = cnt - CW'(1);
            end
            DONE: begin
                if (bus.Mdu_start) begin
                    pend_rd_nxt = bus.Mdu_rd;
                    cnt_nxt     = CW'(MDU_LAT - 2);
                    state_nxt   = BUSY;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.Mdu_busy  = (state == BUSY);
    assign bus.Mdu_done  = (state == DONE);
    assign bus.Mdu_wb_rd = (state == DONE) ? pend_rd : '0;
    assign bus.Mdu_err   = err;

endmodule

// File: doc/fwd_hazard_unit.md
# fwd_hazard_unit

Parametrised forwarding and hazard unit for the 5-stage pipeline. It generalises operand forwarding to NSRC source operands and adds a third forwarding source: a one-cycle write-back history for register files without write-through. It also adds load-use stall detection and a scoreboard/state machine for a multi-cycle multiply/divide unit (MDU). It sits beside the ID/EX register and drives the EX operand-mux selects and the pipeline stall line.

## Interface
- AW, 5: register address width.
- NSRC, 3: number of source operands per instruction (slot i at bits [i*AW +: AW]).
- MDU_LAT, 4: MDU latency in cycles, from issue to result; legal range ≥ 2.
- RF_BYPASS, 0: 1 = register file writes through, so the history path is disabled.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- Ex_Mem_RegWrite, Mem_Wb_RegWrite  in  1  write enables of the EX/MEM and MEM/WB stages.
- Ex_Mem_rd, Mem_Wb_rd  in  AW  destinations of the EX/MEM and MEM/WB stages.
- Id_Ex_src, If_Id_src  in  NSRC*AW  source addresses in the EX and ID stages.
- Id_Ex_src_en, If_Id_src_en  in  NSRC  per-slot source valid.
- Id_Ex_MemRead  in  1  the EX-stage instruction is a load.
- Id_Ex_rd  in  AW  EX-stage destination.
- Mdu_start  in  1  an MDU op issues from EX this cycle.
- Mdu_rd  in  AW  destination of the issuing MDU op.
- If_Id_mdu  in  1  the ID-stage instruction is an MDU op.
- Forward  out  2*NSRC  per-slot select: 00 register file, 10 EX/MEM, 01 MEM/WB, 11 write-back history.
- Stall  out  1  hold PC and IF/ID, and insert a bubble into ID/EX.
- Mdu_busy  out  1  the MDU state is BUSY.
- Mdu_done  out  1  the MDU result is valid for write-back this cycle.
- Mdu_wb_rd  out  AW  destination of the completing MDU op.
- Mdu_err  out  1  sticky flag: Mdu_start was seen while the MDU was not free.

## Operation
- Forwarding, per slot i, evaluated combinationally in priority order:
  - If src_en[i]=0 or the source address is 0, Forward is 00.
  - If Ex_Mem_RegWrite and Ex_Mem_rd equals the source, Forward is 10.
  - Else if Mem_Wb_RegWrite and Mem_Wb_rd equals the source, Forward is 01.
  - Else if RF_BYPASS=0 and Wb_Last_we and Wb_Last_rd equals the source, Forward is 11.
  - Otherwise Forward is 00.
- Write-back history registers:
  - Wb_Last_we is loaded with Mem_Wb_RegWrite every cycle.
  - Wb_Last_rd is loaded with Mem_Wb_rd every cycle.
  - When RF_BYPASS=1 both registers are held at 0.
- Load-use stall: asserted when Id_Ex_MemRead=1, Id_Ex_rd≠0, and Id_Ex_rd matches any enabled, nonzero If_Id_src slot.
- MDU state machine: IDLE, BUSY, DONE.
  - IDLE: on Mdu_start, load pend_rd from Mdu_rd and set cnt to MDU_LAT-2, then go to BUSY.
  - BUSY: if cnt is 0, go to DONE; otherwise decrement cnt.
  - DONE: Mdu_done=1 and Mdu_wb_rd=pend_rd. On Mdu_start, reload and go to BUSY (back-to-back issue); otherwise go to IDLE.
  - Mdu_start in BUSY is ignored, sets Mdu_err, and leaves the state unchanged.
- MDU stall, asserted when either condition holds:
  - The state is BUSY or DONE, pend_rd≠0, and pend_rd matches any enabled If_Id_src slot (RAW).
  - The state is BUSY and If_Id_mdu=1 (structural).
- Stall is the OR of the load-use and MDU stall terms.
- An MDU result enters the normal MEM/WB path on the DONE cycle; the unit does not forward it.
- Reset clears:
  - state to IDLE;
  - cnt, pend_rd, Wb_Last_we and Wb_Last_rd to 0;
  - Mdu_busy, Mdu_done, Mdu_wb_rd and Mdu_err to 0.
- With all inputs inactive, Forward and Stall read 0 during and after reset.
- Reset asserted mid-operation aborts a pending MDU op immediately, so no Mdu_done is issued.

## Timing
- Forward and Stall are combinational from the inputs and the current state, with zero latency.
- The Wb_Last path selects an address exactly one cycle after that address was written in MEM/WB.
- MDU timing, with Mdu_start sampled at edge T:
  - Mdu_busy is 1 for cycles T+1 … T+MDU_LAT-1.
  - Mdu_done is 1 for cycle T+MDU_LAT only.
  - The DONE cycle is MDU_LAT cycles after issue.
- The RAW stall covers cycles T+1 … T+MDU_LAT. A dependent instruction leaves ID at the edge ending cycle T+MDU_LAT+1.
- Back-to-back issue in DONE gives a gapless DONE → BUSY transition; the new op's Mdu_done follows MDU_LAT cycles later.
- The counter is ceil(log2(MDU_LAT)) bits wide and never wraps, because it is reloaded before it could underflow.
- A load-use stall lasts one cycle, because the load has advanced by the next cycle.

## Test plan
- Priority: Ex_Mem_rd=Mem_Wb_rd=Wb_Last_rd=7 with all write enables 1, and slot0 src=7 → Forward[1:0]=10. Then drop Ex_Mem_RegWrite → 01; then drop Mem_Wb_RegWrite → 11 (00 when RF_BYPASS=1).
- Zero register and disable: src=0 with every stage writing rd=0 → 00. src_en[2]=0 while matching Ex_Mem_rd → Forward[5:4]=00.
- Load-use: Id_Ex_MemRead=1, Id_Ex_rd=5, If_Id_src slot1=5 → Stall=1 for one cycle. With If_Id_src_en[1]=0 → Stall=0.
- MDU with MDU_LAT=4:
  - Mdu_start with rd=9 at edge T → Mdu_busy high for T+1..T+3, Mdu_done at T+4, Mdu_wb_rd=9.
  - If_Id_src=9 → Stall during T+1..T+4.
  - If_Id_mdu=1 with no RAW match → Stall during T+1..T+3.
- Back-to-back and error: Mdu_start during DONE → re-enters BUSY with the new pend_rd. Mdu_start during BUSY → Mdu_err=1 and remains set until reset.
- Reset mid-op: drop rst_n at T+2 of an MDU op → Mdu_busy, Mdu_done and Mdu_err are 0 immediately, and no Mdu_done pulse occurs after release.
